viterbi_channel_model: RTL and testbench

Parametrised, synthesizable noisy-channel model that sits between the convolutional encoder and the Viterbi decoder. It replaces the behavioural `$random` injector with a per-symbol LFSR, which makes every run reproducible from a seed. It supports configurable symbol width, trigger rate, burst length and injection window, with a runtime mode select. Error statistics are exported for the bench and for on-chip BER measurement.

---
 rtl/viterbi_pkg.sv | 29 ++
 rtl/viterbi_channel_model_lfsr16.sv | 22 ++
 rtl/viterbi_channel_model.sv | 143 ++++++++++++++
 tb/tb_viterbi_channel_model.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared types and helpers for the Viterbi noisy-channel model.
// Covers the mode and state enums, the LFSR feedback constant and a popcount helper.
package viterbi_pkg;

    typedef enum logic [1:0] {
        MODE_CLEAN  = 2'd0,
        MODE_RANDOM = 2'd1,
        MODE_BURST  = 2'd2
    } chan_mode_t;

    typedef enum logic [1:0] {
        ST_CLEAN = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } chan_state_t;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
    localparam logic [15:0] LFSR_POLY = 16'hB400;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/viterbi_channel_model_lfsr16.sv
// 16-bit Galois LFSR that steps only when adv is high.
// Holding on idle cycles makes the noise depend on symbol count, not on cycle count.
module lfsr16
    import viterbi_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        adv,
    output logic [15:0] state
);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEED;
        end else if (adv) begin
            state <= state[0] ? ((state >> 1) ^ LFSR_POLY) : (state >> 1);
        end
    end

endmodule

// File: rtl/viterbi_channel_model.sv
// Reproducible noisy channel between the convolutional encoder and the Viterbi decoder.
// The channel injects LFSR-driven random or burst errors inside a window and keeps error statistics.
module viterbi_channel_model
    import viterbi_pkg::*;
#(
    parameter int          W         = 2,
    parameter int          TRIG_BITS = 5,
    parameter int          MAX_BURST = 4,
    parameter int          WINDOW    = 256,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter bit          FORCE_NZ  = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   mode_i,
    input  logic         clear_i,
    input  logic         valid_i,
    input  logic [W-1:0] sym_i,
    output logic         valid_o,
    output logic [W-1:0] sym_o,
    output logic [W-1:0] err_mask_o,
    output logic         burst_o,
    output logic [31:0]  word_ct_o,
    output logic [31:0]  err_ct_o,
    output logic [31:0]  bad_bit_ct_o
);

    localparam int          BL_W     = $clog2(MAX_BURST + 1);
    localparam logic [31:0] WINDOW_C = 32'(WINDOW);

    logic [15:0]     lfsr;
    logic            unused_lfsr;
    chan_state_t     state, nstate;
    logic [BL_W-1:0] burst_left, nleft;
    logic            in_win, trig, mode_clean, burst_sym;
    logic [W-1:0]    raw, mask;
    logic [31:0]     word_nxt;
    logic [4:0]      pop;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [4:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {28'd0, b};
        return s[32] ? '1 : s[31:0];
    endfunction

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .adv   (valid_i & ~clear_i),
        .state (lfsr)
    );

    // Only the trigger LSBs and the mask MSBs of the LFSR are consumed.
    assign unused_lfsr = ^lfsr;

    always_comb begin
        in_win     = word_ct_o < WINDOW_C;
        trig       = (&lfsr[TRIG_BITS-1:0]) && in_win;
        raw        = lfsr[15 -: W];
        if (FORCE_NZ && raw == '0) begin
            raw = W'(1);
        end
        mode_clean = (mode_i == MODE_CLEAN) || (mode_i == 2'd3);
        word_nxt   = in_win ? word_ct_o + 32'd1 : word_ct_o;
        mask       = '0;
        nstate     = state;
        nleft      = burst_left;
        burst_sym  = 1'b0;
        if (valid_i) begin
            case (state)
                ST_CLEAN: begin
                    if (!mode_clean && trig) begin
                        mask = raw;
                        if (mode_i == MODE_BURST) begin
                            nleft = BL_W'(MAX_BURST - 1);
                            if (nleft != '0) begin
                                nstate = ST_BURST;
                            end
                        end
                    end
                end
                ST_BURST: begin
                    if (mode_clean) begin
                        nstate = ST_CLEAN;
                        nleft  = '0;
                    end else begin
                        mask      = raw;
                        burst_sym = 1'b1;
                        nleft     = burst_left - BL_W'(1);
                        if (burst_left == BL_W'(1)) begin
                            nstate = ST_CLEAN;
                        end
                    end
                end
                default: ;
            endcase
            // Reaching the window end overrides any burst still in flight.
            if (word_nxt >= WINDOW_C) begin
                nstate = ST_DONE;
                nleft  = '0;
            end
        end
        pop = popcount16(16'(mask));
    end

    // Output register stage: one-cycle latency from the presented symbol.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o      <= 1'b0;
            sym_o        <= '0;
            err_mask_o   <= '0;
            burst_o      <= 1'b0;
            word_ct_o    <= '0;
            err_ct_o     <= '0;
            bad_bit_ct_o <= '0;
            state        <= ST_CLEAN;
            burst_left   <= '0;
        end else if (clear_i) begin
            valid_o      <= valid_i;
            sym_o        <= sym_i;
            err_mask_o   <= '0;
            burst_o      <= 1'b0;
            word_ct_o    <= '0;
            err_ct_o     <= '0;
            bad_bit_ct_o <= '0;
            state        <= ST_CLEAN;
            burst_left   <= '0;
        end else begin
            valid_o    <= valid_i;
            sym_o      <= sym_i ^ mask;
            err_mask_o <= mask;
            burst_o    <= (nstate == ST_BURST) || burst_sym;
            state      <= nstate;
            burst_left <= nleft;
            if (valid_i) begin
                word_ct_o    <= word_nxt;
                err_ct_o     <= sat_add(err_ct_o, {4'd0, mask != '0});
                bad_bit_ct_o <= sat_add(bad_bit_ct_o, pop);
            end
        end
    end

endmodule

// File: tb/tb_viterbi_channel_model.sv
// Self-checking bench: two channel instances (window 256 and 8) share one stimulus.
// A symbol-level reference model predicts every output cycle; literal values pin the model.
module tb_viterbi_channel_model;
    import viterbi_pkg::*;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam int TB   = 1;
    localparam int MAXB = 4;

    logic clk = 1'b0;
    logic rst, clear, valid;
    logic [1:0] sym, mode;

    logic        a_valid, b_valid, a_burst, b_burst;
    logic [1:0]  a_sym, b_sym, a_mask, b_mask;
    logic [31:0] a_word, b_word, a_err, b_err, a_bad, b_bad;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    viterbi_channel_model #(.W(2), .TRIG_BITS(TB), .MAX_BURST(MAXB), .WINDOW(256),
                            .SEED(SEED), .FORCE_NZ(1'b1)) dut_a (
        .clk(clk), .rst(rst), .mode_i(mode), .clear_i(clear), .valid_i(valid), .sym_i(sym),
        .valid_o(a_valid), .sym_o(a_sym), .err_mask_o(a_mask), .burst_o(a_burst),
        .word_ct_o(a_word), .err_ct_o(a_err), .bad_bit_ct_o(a_bad));

    viterbi_channel_model #(.W(2), .TRIG_BITS(TB), .MAX_BURST(MAXB), .WINDOW(8),
                            .SEED(SEED), .FORCE_NZ(1'b1)) dut_b (
        .clk(clk), .rst(rst), .mode_i(mode), .clear_i(clear), .valid_i(valid), .sym_i(sym),
        .valid_o(b_valid), .sym_o(b_sym), .err_mask_o(b_mask), .burst_o(b_burst),
        .word_ct_o(b_word), .err_ct_o(b_err), .bad_bit_ct_o(b_bad));

    typedef struct {
        logic [15:0] lfsr;
        int unsigned word, err, bad;
        int          left;
        logic        vo, bo;
        logic [1:0]  so, mo;
    } mdl_t;

    mdl_t ma, mb;

    // One symbol of channel behaviour; 'left' is the count of burst symbols still owed.
    function automatic mdl_t step(mdl_t m, int unsigned window, logic r, logic c, logic v,
                                  logic [1:0] s, logic [1:0] md);
        logic [1:0] raw, mk;
        logic       inwin, trig, hit;
        if (r) begin
            m.lfsr = SEED; m.word = 0; m.err = 0; m.bad = 0; m.left = 0;
            m.vo = 0; m.so = 0; m.mo = 0; m.bo = 0;
            return m;
        end
        if (c) begin
            m.word = 0; m.err = 0; m.bad = 0; m.left = 0;
            m.vo = v; m.so = s; m.mo = 0; m.bo = 0;
            return m;
        end
        m.vo = v; m.so = s; m.mo = 0;
        if (!v) begin
            m.bo = (m.left > 0);
            return m;
        end
        inwin = (m.word < window);
        raw   = m.lfsr[15:14];
        if (raw == 2'd0) raw = 2'd1;
        trig  = ((int'(m.lfsr) % (1 << TB)) == (1 << TB) - 1) && inwin;
        mk = 2'd0; hit = 1'b0;
        if (md == 2'd0 || md == 2'd3) begin
            m.left = 0;
        end else if (inwin) begin
            if (m.left > 0) begin
                mk = raw; m.left = m.left - 1; hit = 1'b1;
            end else if (trig) begin
                mk = raw;
                if (md == 2'd2) m.left = MAXB - 1;
            end
        end
        if (inwin) m.word = m.word + 1;
        if (m.word >= window) m.left = 0;
        m.err = m.err + ((mk != 2'd0) ? 1 : 0);
        m.bad = m.bad + int'(mk[0]) + int'(mk[1]);
        m.so  = s ^ mk;
        m.mo  = mk;
        m.bo  = hit || (m.left > 0);
        m.lfsr = m.lfsr[0] ? ((m.lfsr >> 1) ^ 16'hB400) : (m.lfsr >> 1);
        return m;
    endfunction

    always @(posedge clk) begin
        ma = step(ma, 256, rst, clear, valid, sym, mode);
        mb = step(mb, 8, rst, clear, valid, sym, mode);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("a_valid", 32'(a_valid), 32'(ma.vo));
            chk("a_sym",   32'(a_sym),   32'(ma.so));
            chk("a_mask",  32'(a_mask),  32'(ma.mo));
            chk("a_burst", 32'(a_burst), 32'(ma.bo));
            chk("a_word",  a_word, ma.word);
            chk("a_err",   a_err,  ma.err);
            chk("a_bad",   a_bad,  ma.bad);
            chk("b_valid", 32'(b_valid), 32'(mb.vo));
            chk("b_sym",   32'(b_sym),   32'(mb.so));
            chk("b_mask",  32'(b_mask),  32'(mb.mo));
            chk("b_burst", 32'(b_burst), 32'(mb.bo));
            chk("b_word",  b_word, mb.word);
            chk("b_err",   b_err,  mb.err);
            chk("b_bad",   b_bad,  mb.bad);
        end
    end

    task automatic drive(input logic v, input logic [1:0] s, input logic [1:0] md,
                         input logic c, input logic r);
        rst = r; clear = c; valid = v; sym = s; mode = md;
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic v, input logic [1:0] s, input logic [1:0] md);
        drive(v, s, md, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; valid = 1'b0; sym = 2'd0; mode = 2'd0;
        drive(1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
        chk_on = 1'b1;
        chk("rst_valid", 32'(a_valid), 32'd0);
        chk("rst_sym",   32'(a_sym),   32'd0);
        chk("rst_burst", 32'(a_burst), 32'd0);
        chk("rst_word",  a_word, 32'd0);
        chk("rst_lfsr",  32'(dut_a.u_lfsr.state), 32'(SEED));

        // Random mode from the seed: masks 2,0,0,0,0,1,2 for the first seven symbols.
        for (int i = 0; i < 256; i++) begin
            go(1'b1, 2'(i % 4), 2'd1);
            if (i == 0) begin
                chk("rnd_mask0", 32'(a_mask), 32'd2);
                chk("rnd_sym0",  32'(a_sym),  32'd2);
            end
            if (i == 5) begin
                chk("rnd_err5", a_err, 32'd2);
                chk("rnd_bad5", a_bad, 32'd2);
            end
            if (i == 6) begin
                chk("rnd_err6", a_err, 32'd3);
                chk("rnd_bad6", a_bad, 32'd3);
            end
        end

        drive(1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) go(1'b1, 2'(i % 4), 2'd0);
        chk("clean_word_a", a_word, 32'd256);
        chk("clean_err_a",  a_err,  32'd0);
        chk("clean_word_b", b_word, 32'd8);

        // Burst from the seed: masks 2,3,1,1 then a clean symbol; a gap sits inside.
        drive(1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
        go(1'b1, 2'd1, 2'd2);
        chk("bst_mask0", 32'(a_mask), 32'd2);
        chk("bst_on0",   32'(a_burst), 32'd1);
        go(1'b1, 2'd2, 2'd2);
        chk("bst_sym1",  32'(a_sym), 32'd1);
        go(1'b0, 2'd0, 2'd2);
        chk("bst_gap",   32'(a_burst), 32'd1);
        go(1'b1, 2'd3, 2'd2);
        go(1'b1, 2'd0, 2'd2);
        chk("bst_mask3", 32'(a_mask), 32'd1);
        chk("bst_on3",   32'(a_burst), 32'd1);
        go(1'b1, 2'd0, 2'd2);
        chk("bst_off4",  32'(a_burst), 32'd0);
        chk("bst_err",   a_err, 32'd4);
        chk("bst_bad",   a_bad, 32'd5);
        for (int i = 0; i < 200; i++) begin
            for (int g = 0; g < i % 4; g++) go(1'b0, 2'd0, 2'd2);
            go(1'b1, 2'(i % 4), 2'd2);
        end

        // Window end on the 8-symbol instance, then clear and continue.
        drive(1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) go(1'b1, 2'(i % 4), 2'd1);
        chk("win_word", b_word, 32'd8);
        chk("win_mask", 32'(b_mask), 32'd0);
        chk("win_done", 32'(dut_b.state), 32'(ST_DONE));
        drive(1'b1, 2'd1, 2'd1, 1'b1, 1'b0);
        chk("clr_sym",  32'(b_sym), 32'd1);
        chk("clr_word", b_word, 32'd0);
        chk("clr_err",  b_err, 32'd0);
        for (int i = 0; i < 10; i++) go(1'b1, 2'(i % 4), 2'd1);
        chk("win2_word", b_word, 32'd8);

        // Clear in the second burst symbol.
        drive(1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
        go(1'b1, 2'd0, 2'd2);
        drive(1'b1, 2'd3, 2'd2, 1'b1, 1'b0);
        chk("abc_sym",   32'(a_sym), 32'd3);
        chk("abc_mask",  32'(a_mask), 32'd0);
        chk("abc_burst", 32'(a_burst), 32'd0);
        chk("abc_err",   a_err, 32'd0);
        go(1'b1, 2'd0, 2'd2);
        chk("abc_next",  32'(a_burst), 32'd0);
        for (int i = 0; i < 8; i++) go(1'b1, 2'(i % 4), 2'd2);

        // Reset in the second burst symbol.
        drive(1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
        go(1'b1, 2'd0, 2'd2);
        drive(1'b1, 2'd3, 2'd2, 1'b0, 1'b1);
        chk("abr_sym",   32'(a_sym), 32'd0);
        chk("abr_burst", 32'(a_burst), 32'd0);
        chk("abr_word",  a_word, 32'd0);
        chk("abr_lfsr",  32'(dut_a.u_lfsr.state), 32'(SEED));
        go(1'b1, 2'd0, 2'd2);
        chk("abr_mask",  32'(a_mask), 32'd2);

        // One clean-mode symbol inside a burst ends it for good.
        drive(1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
        go(1'b1, 2'd0, 2'd2);
        go(1'b1, 2'd1, 2'd0);
        chk("msw_sym",   32'(a_sym), 32'd1);
        chk("msw_burst", 32'(a_burst), 32'd0);
        go(1'b1, 2'd2, 2'd2);
        chk("msw_mask",  32'(a_mask), 32'd0);
        chk("msw_nores", 32'(a_burst), 32'd0);
        for (int i = 0; i < 8; i++) go(1'b1, 2'(i % 4), 2'd2);

        go(1'b0, 2'd0, 2'd0);
        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
